spi_transfer_controller: RTL and testbench

Single-character SPI master controller. It sequences one transfer of CHAR_LENGTH bits per request. It drives chip select with chip-to-transaction (c2t) and transaction-to-chip (t2c) delays, generates sclk from a baud-rate divisor for any CPOL/CPHA mode, shifts mosi0 out, samples miso0 in, and enforces an inter-transfer gap (wdelay). It sits between a register or sequence front end and the SPI pins.

---
 rtl/spi_transfer_controller_pkg.sv | 30 +++
 rtl/spi_clock_divider.sv | 41 ++++
 rtl/spi_transfer_controller.sv | 177 +++++++++++++++++
 tb/tb_spi_transfer_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_transfer_controller_pkg.sv
// spi_transfer_controller_pkg: shared types and default sizes for the SPI
// transfer controller and its clock divider.
package spi_transfer_controller_pkg;

  localparam int CHAR_LENGTH_DEF = 8;
  localparam int DIV_WIDTH_DEF   = 16;
  localparam int DELAY_WIDTH_DEF = 8;

  // SPI mode encoded as {cpol, cpha}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } op_mode_e;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } shift_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_C2T,
    ST_SHIFT,
    ST_T2C,
    ST_WDELAY
  } ctrl_state_e;

endpackage

// File: rtl/spi_clock_divider.sv
// spi_clock_divider: emits a one-cycle tick every max(div,1) pclk cycles while
// enabled, and flags whether that tick is a leading or trailing sclk edge.
module spi_clock_divider
  import spi_transfer_controller_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 leading
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] last;

  // a divisor of zero behaves as one
  always_comb begin
    last = (div == '0) ? '0 : div - 1'b1;
    tick = en && (cnt == last);
  end

  // half-period counter; the phase flag restarts as "leading" whenever disabled
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      cnt     <= '0;
      leading <= 1'b1;
    end else if (!en) begin
      cnt     <= '0;
      leading <= 1'b1;
    end else if (tick) begin
      cnt     <= '0;
      leading <= ~leading;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_transfer_controller.sv
// spi_transfer_controller: single-character SPI master. Sequences chip select
// with c2t/t2c delays, generates sclk for any CPOL/CPHA, shifts one character
// out on mosi0 and in from miso0, then holds busy for the wdelay gap.
// Optional build macro SPI_LOOPBACK_EN: sample mosi0 internally instead of
// miso0 (built-in self-test); miso0 is then ignored.
module spi_transfer_controller
  import spi_transfer_controller_pkg::*;
#(
  parameter int NO_OF_SLAVES = 1,
  parameter int CHAR_LENGTH  = CHAR_LENGTH_DEF,
  parameter int DIV_WIDTH    = DIV_WIDTH_DEF,
  parameter int DELAY_WIDTH  = DELAY_WIDTH_DEF
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [NO_OF_SLAVES-1:0] csMask,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    msbFirst,
  input  logic [DIV_WIDTH-1:0]    baudrateDivisor,
  input  logic [DELAY_WIDTH-1:0]  c2t,
  input  logic [DELAY_WIDTH-1:0]  t2c,
  input  logic [DELAY_WIDTH-1:0]  wdelay,
  input  logic [CHAR_LENGTH-1:0]  txData,
  output logic                    busy,
  output logic                    done,
  output logic [CHAR_LENGTH-1:0]  rxData,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  input  logic                    miso0
);

  localparam int                   EW        = $clog2(2 * CHAR_LENGTH);
  localparam logic [EW-1:0]        LAST_EDGE = EW'(2 * CHAR_LENGTH - 1);
  localparam logic [DELAY_WIDTH-1:0] ONE     = DELAY_WIDTH'(1);

  ctrl_state_e              state;
  op_mode_e                 mode_q;
  shift_dir_e               dir_q;
  logic [DIV_WIDTH-1:0]     div_q;
  logic [DELAY_WIDTH-1:0]   t2c_q, wd_q, dcnt;
  logic [EW-1:0]            ecnt;
  logic [CHAR_LENGTH-1:0]   tx_sh, rx_sh, tx_nxt, rx_nxt;
  logic                     tick, leading, sdi;
  logic                     last_edge, sample_evt, drive_evt, fin;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso0;
  assign sdi         = mosi0;
`else
  assign sdi = miso0;
`endif

  spi_clock_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .pclk    (pclk),
    .areset  (areset),
    .en      (state == ST_SHIFT),
    .div     (div_q),
    .tick    (tick),
    .leading (leading)
  );

  // edge classification and next shift-register contents
  always_comb begin
    last_edge  = (ecnt == LAST_EDGE);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    sample_evt = tick && (leading ^ mode_q[0]);
    // first bit is already on mosi0 from accept, so neither the first CPHA=1
    // leading edge nor the final CPHA=0 trailing edge advances the data
    drive_evt  = tick && (mode_q[0] ? (leading && ecnt != '0) : (!leading && !last_edge));
    tx_nxt     = (dir_q == MSB_FIRST) ? {tx_sh[CHAR_LENGTH-2:0], 1'b0}
                                      : {1'b0, tx_sh[CHAR_LENGTH-1:1]};
    rx_nxt     = rx_sh;
    if (sample_evt)
      rx_nxt = (dir_q == MSB_FIRST) ? {rx_sh[CHAR_LENGTH-2:0], sdi}
                                    : {sdi, rx_sh[CHAR_LENGTH-1:1]};
    fin = (state == ST_SHIFT && tick && last_edge && t2c_q == '0) ||
          (state == ST_T2C && dcnt == ONE);
  end

  // transfer sequencer: delays, sclk edges, shifting and registered outputs
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state  <= ST_IDLE;
      mode_q <= MODE0;
      dir_q  <= LSB_FIRST;
      div_q  <= '0;
      t2c_q  <= '0;
      wd_q   <= '0;
      dcnt   <= '0;
      ecnt   <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rxData <= '0;
      sclk   <= 1'b0;
      cs     <= '1;
      mosi0  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && csMask != '0) begin
            mode_q <= op_mode_e'({cpol, cpha});
            dir_q  <= shift_dir_e'(msbFirst);
            div_q  <= baudrateDivisor;
            t2c_q  <= t2c;
            wd_q   <= wdelay;
            tx_sh  <= txData;
            rx_sh  <= '0;
            ecnt   <= '0;
            busy   <= 1'b1;
            cs     <= ~csMask;
            sclk   <= cpol;
            mosi0  <= msbFirst ? txData[CHAR_LENGTH-1] : txData[0];
            if (c2t == '0) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_C2T;
              dcnt  <= c2t;
            end
          end
        end
        ST_C2T: begin
          if (dcnt == ONE) state <= ST_SHIFT;
          else             dcnt  <= dcnt - ONE;
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk  <= ~sclk;
            ecnt  <= ecnt + 1'b1;
            rx_sh <= rx_nxt;
            if (drive_evt) begin
              tx_sh <= tx_nxt;
              mosi0 <= (dir_q == MSB_FIRST) ? tx_nxt[CHAR_LENGTH-1] : tx_nxt[0];
            end
            if (last_edge && t2c_q != '0) begin
              state <= ST_T2C;
              dcnt  <= t2c_q;
            end
          end
        end
        ST_T2C: begin
          if (dcnt != ONE) dcnt <= dcnt - ONE;
        end
        ST_WDELAY: begin
          if (dcnt == ONE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt - ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // end of character: release cs, publish data, start the gap
      if (fin) begin
        cs     <= '1;
        done   <= 1'b1;
        rxData <= rx_nxt;
        sclk   <= mode_q[1];
        if (wd_q == '0) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          state <= ST_WDELAY;
          dcnt  <= wd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// tb_spi_transfer_controller: randomized and directed transfers checked every
// cycle against a timeline model derived from accept time and the latched
// configuration, plus literal latency/data pins for the directed cases.
module tb_spi_transfer_controller;

  localparam int NS = 4;
  localparam int CL = 8;
  localparam int DW = 16;
  localparam int LW = 8;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          areset = 1'b0;
  logic          start = 1'b0, cpol = 1'b0, cpha = 1'b0, msbFirst = 1'b1;
  logic [NS-1:0] csMask = '0;
  logic [DW-1:0] baudrateDivisor = '0;
  logic [LW-1:0] c2t = '0, t2c = '0, wdelay = '0;
  logic [CL-1:0] txData = '0, slave_word = '0;
  logic          miso0 = 1'b0;
  logic          busy, done, sclk, mosi0;
  logic [CL-1:0] rxData;
  logic [NS-1:0] cs;

  int n_cmp = 0, n_bad = 0, n_done = 0;

  always #5 pclk = ~pclk;

  spi_transfer_controller #(
    .NO_OF_SLAVES(NS), .CHAR_LENGTH(CL), .DIV_WIDTH(DW), .DELAY_WIDTH(LW)
  ) dut (
    .pclk(pclk), .areset(areset), .start(start), .csMask(csMask),
    .cpol(cpol), .cpha(cpha), .msbFirst(msbFirst),
    .baudrateDivisor(baudrateDivisor), .c2t(c2t), .t2c(t2c), .wdelay(wdelay),
    .txData(txData), .busy(busy), .done(done), .rxData(rxData),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one accepted transfer at a time --------
  int            cyc = 0;
  logic          have = 1'b0;
  int            n0 = 0, m_c2t = 0, m_t2c = 0, m_wd = 0, m_div = 1;
  logic          m_cpol = 1'b0, m_cpha = 1'b0, m_msb = 1'b0;
  logic [NS-1:0] m_mask = '0;
  logic [CL-1:0] m_tx = '0, m_word = '0, m_prev = '0;

  always @(posedge pclk) cyc <= cyc + 1;

  // accept to done, in cycles
  function automatic int span();
    return 1 + m_c2t + 2 * CL * m_div + m_t2c;
  endfunction

  always @(posedge pclk or negedge areset) begin
    if (!areset) begin
      have   <= 1'b0;
      m_prev <= '0;
    end else if (start && csMask != '0 && (!have || cyc - n0 >= span() + m_wd)) begin
      m_prev <= have ? m_word : '0;
      have   <= 1'b1;
      n0     <= cyc;
      m_c2t  <= int'(c2t);
      m_t2c  <= int'(t2c);
      m_wd   <= int'(wdelay);
      m_div  <= (baudrateDivisor == '0) ? 1 : int'(baudrateDivisor);
      m_cpol <= cpol;
      m_cpha <= cpha;
      m_msb  <= msbFirst;
      m_mask <= csMask;
      m_tx   <= txData;
      m_word <= LOOPBACK ? txData : slave_word;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge pclk) begin
    int t, e, idx, lead;
    logic [NS-1:0] e_cs;
    t = cyc - n0;
    e = (t < 1 + m_c2t) ? 0 : (t - 1 - m_c2t) / m_div;
    if (e > 2 * CL) e = 2 * CL;
    lead = (e + 1) / 2;
    idx  = m_cpha ? ((lead == 0) ? 0 : lead - 1) : e / 2;
    if (idx > CL - 1) idx = CL - 1;
    if (have) begin
      e_cs = (t >= 1 && t < span()) ? ~m_mask : {NS{1'b1}};
      chk("busy",   busy,   t >= 1 && t < span() + m_wd);
      chk("cs",     cs,     e_cs);
      chk("done",   done,   t == span());
      chk("rxData", rxData, (t >= span()) ? m_word : m_prev);
      chk("sclk",   sclk,   m_cpol ^ e[0]);
      chk("mosi0",  mosi0,  m_msb ? m_tx[CL-1-idx] : m_tx[idx]);
    end else begin
      chk("idle_busy", busy,   1'b0);
      chk("idle_cs",   cs,     {NS{1'b1}});
      chk("idle_done", done,   1'b0);
      chk("idle_rx",   rxData, m_prev);
      chk("idle_sclk", sclk,   1'b0);
      chk("idle_mosi", mosi0,  1'b0);
    end
    if (done) n_done <= n_done + 1;
  end

  // ---------------- bench slave: presents slave_word on miso0 ---------------
  int   ne = 0;
  logic sclk_prev = 1'b0, cs_idle_prev = 1'b1;
  always @(negedge pclk) begin
    int nx, k;
    if (&cs) nx = 0;
    else if (!cs_idle_prev && sclk !== sclk_prev) nx = ne + 1;
    else nx = ne;
    k = cpha ? ((nx == 0) ? 0 : (nx - 1) / 2) : nx / 2;
    if (k > CL - 1) k = CL - 1;
    ne           <= nx;
    sclk_prev    <= sclk;
    cs_idle_prev <= &cs;
    miso0        <= msbFirst ? slave_word[CL-1-k] : slave_word[k];
  end

  // one transfer; latencies are in cycles after the accepting edge
  task automatic xfer(input logic pl, ph, mf, input int dv, a, b, w,
                      input logic [NS-1:0] m, input logic [CL-1:0] tx, sw,
                      output int lat_d, output int lat_i, output logic [NS-1:0] cs1);
    int k;
    cpol = pl; cpha = ph; msbFirst = mf;
    baudrateDivisor = DW'(dv); c2t = LW'(a); t2c = LW'(b); wdelay = LW'(w);
    csMask = m; txData = tx; slave_word = sw;
    start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
    cs1 = cs;
    k = 1;
    while (!done && k < 4000) begin @(posedge pclk); #1; k++; end
    chk("done_seen", done, 1'b1);
    lat_d = k;
    while (busy && k < 8000) begin @(posedge pclk); #1; k++; end
    chk("busy_released", busy, 1'b0);
    lat_i = k;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld, li, nd0;
    logic [NS-1:0] c1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx",   rxData, 8'h00);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_cs",   cs, 4'hF);
    chk("rst_mosi", mosi0, 1'b0);
    @(posedge pclk); #1 areset = 1'b1;
    repeat (2) @(posedge pclk); #1;

    // mode 0: done at 37, busy low at 40
    xfer(1'b0, 1'b0, 1'b1, 2, 2, 2, 3, 4'b0001, 8'hA5, 8'hA5, ld, li, c1);
    chk("m0_done_cycle", ld, 37);
    chk("m0_busy_low",   li, 40);
    chk("m0_rx",         rxData, 8'hA5);

    // mode 3, LSB first: done 17 cycles after accept, sclk idles high
    xfer(1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 4'b0001, 8'h01, 8'h3C, ld, li, c1);
    chk("m3_done_cycle", ld, 17);
    chk("m3_rx",         rxData, LOOPBACK ? 8'h01 : 8'h3C);
    chk("m3_sclk_idle",  sclk, 1'b1);

    // divisor 0 behaves as 1
    xfer(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 4'b1000, 8'h5A, 8'h81, ld, li, c1);
    chk("div0_done_cycle", ld, 17);

    // start with an empty mask is ignored
    csMask = '0; start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
    repeat (3) begin chk("mask0_busy", busy, 1'b0); @(posedge pclk); #1; end

    // a start pulse during SHIFT is ignored: exactly one done
    nd0 = n_done;
    fork
      xfer(1'b0, 1'b0, 1'b1, 2, 1, 1, 1, 4'b0010, 8'h3C, 8'hC3, ld, li, c1);
      begin
        repeat (12) @(posedge pclk);
        #2 start = 1'b1;
        @(posedge pclk); #2 start = 1'b0;
      end
    join
    repeat (4) @(posedge pclk); #1;
    chk("single_done", n_done - nd0, 1);

    // reset at bit 4 of SHIFT (sclk high there), then a normal transfer
    cpol = 1'b0; cpha = 1'b0; msbFirst = 1'b1; baudrateDivisor = 16'd2;
    c2t = 8'd1; t2c = 8'd1; wdelay = 8'd1; csMask = 4'b0001; txData = 8'h96;
    start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
    repeat (19) @(posedge pclk);
    #2 areset = 1'b0;
    #1;
    chk("abort_cs",   cs, 4'hF);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_busy", busy, 1'b0);
    @(posedge pclk); #1 areset = 1'b1;
    repeat (2) @(posedge pclk); #1;
    xfer(1'b0, 1'b0, 1'b1, 1, 1, 1, 0, 4'b0001, 8'h69, 8'h69, ld, li, c1);
    chk("post_rst_done", ld, 1 + 1 + 16 + 1);
    chk("post_rst_rx",   rxData, 8'h69);

    // multi-slave: only cs[2] goes low
    xfer(1'b0, 1'b1, 1'b0, 3, 1, 2, 0, 4'b0100, 8'hE7, 8'h18, ld, li, c1);
    chk("multi_cs", c1, 4'b1011);

    // randomized transfers
    for (int i = 0; i < 30; i++) begin
      logic [NS-1:0] rm;
      rm = NS'($urandom_range(1, (1 << NS) - 1));
      xfer(1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           rm, CL'($urandom), CL'($urandom), ld, li, c1);
      repeat ($urandom_range(0, 2)) begin @(posedge pclk); #1; end
    end

    repeat (3) @(posedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
